// File: rtl/pc_sequencer_pkg.sv
// pc_seq_pkg: shared types for the program-counter sequencer.
//   state_e     - sequencer FSM encoding (IDLE=0 .. DONE=4), exported on o_state
//   redir_src_e - which source currently redirects the PC
//   NB_ADDR_DEF - default PC / target address width
package pc_seq_pkg;

  localparam int NB_ADDR_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_BRANCH = 2'd1,
    REDIR_JUMP   = 2'd2
  } redir_src_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_seq_if: redirect requests from hazard unit / ID / EX and the resulting
// PC control lines.
//   master - the sequencer: takes requests, drives PC jump/halt/stall + flushes
//   slave  - the pipeline side: drives requests, observes PC control
interface pc_seq_if #(parameter int NB_ADDR = 32);
  logic               i_hazard_stall;
  logic               i_br_taken;
  logic [NB_ADDR-1:0] i_br_target;
  logic               i_jmp_valid;
  logic [NB_ADDR-1:0] i_jmp_target;
  logic               o_pc_jump;
  logic [NB_ADDR-1:0] o_pc_addr2jump;
  logic               o_pc_halt;
  logic               o_pc_stall;
  logic               o_flush_if;
  logic               o_flush_id;

  modport master (
    input  i_hazard_stall, i_br_taken, i_br_target, i_jmp_valid, i_jmp_target,
    output o_pc_jump, o_pc_addr2jump, o_pc_halt, o_pc_stall, o_flush_if, o_flush_id
  );

  modport slave (
    output i_hazard_stall, i_br_taken, i_br_target, i_jmp_valid, i_jmp_target,
    input  o_pc_jump, o_pc_addr2jump, o_pc_halt, o_pc_stall, o_flush_if, o_flush_id
  );
endinterface

// File: rtl/pc_sequencer_redirect_arbiter.sv
// pc_redirect_arbiter: combinational redirect priority.
//   i_active          - sequencer is in RUN/STEP (otherwise everything is 0)
//   i_br_taken/target - EX branch, highest priority, overrides stall
//   i_jmp_valid/target- ID jump, held off while the hazard unit stalls
//   i_hazard_stall    - load-use stall request
//   o_jump/o_addr     - PC jump and address (address 0 when no jump)
//   o_flush_if/id     - pipeline register flushes
//   o_stall           - PC stall
module pc_redirect_arbiter
  import pc_seq_pkg::*;
#(
  parameter int NB_ADDR = NB_ADDR_DEF
) (
  input  logic               i_active,
  input  logic               i_br_taken,
  input  logic [NB_ADDR-1:0] i_br_target,
  input  logic               i_jmp_valid,
  input  logic [NB_ADDR-1:0] i_jmp_target,
  input  logic               i_hazard_stall,
  output logic               o_jump,
  output logic [NB_ADDR-1:0] o_addr,
  output logic               o_flush_if,
  output logic               o_flush_id,
  output logic               o_stall
);

  redir_src_e w_src;

  always_comb begin
    w_src = REDIR_NONE;
    if (i_active) begin
      if (i_br_taken)                         w_src = REDIR_BRANCH;
      else if (i_jmp_valid && !i_hazard_stall) w_src = REDIR_JUMP;
    end
  end

  always_comb begin
    o_jump     = 1'b0;
    o_addr     = '0;
    o_flush_if = 1'b0;
    o_flush_id = 1'b0;
    o_stall    = 1'b0;
    case (w_src)
      REDIR_BRANCH: begin
        // branch is older than the hazard, so it wins over the stall
        o_jump     = 1'b1;
        o_addr     = i_br_target;
        o_flush_if = 1'b1;
        o_flush_id = 1'b1;
      end
      REDIR_JUMP: begin
        o_jump     = 1'b1;
        o_addr     = i_jmp_target;
        o_flush_if = 1'b1;
      end
      default: o_stall = i_active & i_hazard_stall;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: drives PC jump/halt/stall from redirects, hazards and the
// debug unit (run / single step / stop / HALT drain).
//   clk, i_rst        - clock, asynchronous active-high reset
//   i_dbg_run/step/stop - debug pulses
//   i_halt_instr      - HALT opcode in ID
//   bus (master)      - redirect requests in, PC control + flushes out
//   o_state           - FSM state (IDLE=0 RUN=1 STEP=2 DRAIN=3 DONE=4)
//   o_halted          - registered, high in DONE
//   o_step_done       - registered 1-cycle pulse when a step completes
// Optional: PC_SEQ_BKPT_EN adds i_pc, i_bkpt_addr, i_bkpt_valid, o_bkpt_hit
// (single hardware breakpoint, checked in RUN only).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int NB_ADDR      = NB_ADDR_DEF,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               i_rst,
`ifdef PC_SEQ_BKPT_EN
  input  logic [NB_ADDR-1:0] i_pc,
  input  logic [NB_ADDR-1:0] i_bkpt_addr,
  input  logic               i_bkpt_valid,
  output logic               o_bkpt_hit,
`endif
  input  logic               i_dbg_run,
  input  logic               i_dbg_step,
  input  logic               i_dbg_stop,
  input  logic               i_halt_instr,
  pc_seq_if.master           bus,
  output logic [2:0]         o_state,
  output logic               o_halted,
  output logic               o_step_done
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  state_e             r_state;
  logic [CNT_W-1:0]   r_drain_cnt;
  logic               w_run_or_step;
  logic               w_bkpt;
  logic               w_active;
  logic               w_jump;
  logic [NB_ADDR-1:0] w_addr;
  logic               w_flush_if;
  logic               w_flush_id;
  logic               w_stall;

  assign w_run_or_step = (r_state == ST_RUN) || (r_state == ST_STEP);

`ifdef PC_SEQ_BKPT_EN
  assign w_bkpt = (r_state == ST_RUN) && i_bkpt_valid &&
                  (i_pc == i_bkpt_addr) && !bus.i_br_taken;
`else
  assign w_bkpt = 1'b0;
`endif

  // a breakpoint hit halts the PC in the same cycle, so no redirect either
  assign w_active = w_run_or_step && !w_bkpt;

  pc_redirect_arbiter #(.NB_ADDR(NB_ADDR)) u_arb (
    .i_active       (w_active),
    .i_br_taken     (bus.i_br_taken),
    .i_br_target    (bus.i_br_target),
    .i_jmp_valid    (bus.i_jmp_valid),
    .i_jmp_target   (bus.i_jmp_target),
    .i_hazard_stall (bus.i_hazard_stall),
    .o_jump         (w_jump),
    .o_addr         (w_addr),
    .o_flush_if     (w_flush_if),
    .o_flush_id     (w_flush_id),
    .o_stall        (w_stall)
  );

  assign bus.o_pc_jump      = w_jump;
  assign bus.o_pc_addr2jump = w_addr;
  assign bus.o_flush_if     = w_flush_if;
  assign bus.o_flush_id     = w_flush_id;
  assign bus.o_pc_stall     = w_stall;
  assign bus.o_pc_halt      = !w_active;
  assign o_state            = r_state;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= '0;
      o_halted    <= 1'b0;
      o_step_done <= 1'b0;
`ifdef PC_SEQ_BKPT_EN
      o_bkpt_hit  <= 1'b0;
`endif
    end else begin
      o_step_done <= 1'b0;
`ifdef PC_SEQ_BKPT_EN
      o_bkpt_hit  <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (i_dbg_run)       r_state <= ST_RUN;
          else if (i_dbg_step) r_state <= ST_STEP;
        end
        ST_RUN: begin
          // a taken branch makes a same-cycle HALT wrong-path
          if (bus.i_br_taken) begin
            r_state <= ST_RUN;
          end else if (w_bkpt) begin
            r_state <= ST_IDLE;
`ifdef PC_SEQ_BKPT_EN
            o_bkpt_hit <= 1'b1;
`endif
          end else if (i_halt_instr && !bus.i_hazard_stall) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
          end else if (i_dbg_stop) begin
            r_state <= ST_IDLE;
          end
        end
        ST_STEP: begin
          // a stalled step has not advanced yet; retry next cycle
          if (w_stall) begin
            r_state <= ST_STEP;
          end else if (i_halt_instr && !bus.i_br_taken) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
          end else begin
            r_state     <= ST_IDLE;
            o_step_done <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == '0) begin
            r_state  <= ST_DONE;
            o_halted <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          o_halted <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; breakpoint section only with PC_SEQ_BKPT_EN.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_dbg_run, i_dbg_step, i_dbg_stop, i_halt_instr;
  logic [2:0]  o_state;
  logic        o_halted, o_step_done;
`ifdef PC_SEQ_BKPT_EN
  logic [31:0] i_pc, i_bkpt_addr;
  logic        i_bkpt_valid, o_bkpt_hit;
`endif

  int n_chk = 0;
  int n_err = 0;
  int pulses;

  always #5 clk = ~clk;

  pc_seq_if #(.NB_ADDR(32)) bus ();

  pc_sequencer #(.NB_ADDR(32), .DRAIN_CYCLES(4)) dut (
    .clk          (clk),
    .i_rst        (i_rst),
`ifdef PC_SEQ_BKPT_EN
    .i_pc         (i_pc),
    .i_bkpt_addr  (i_bkpt_addr),
    .i_bkpt_valid (i_bkpt_valid),
    .o_bkpt_hit   (o_bkpt_hit),
`endif
    .i_dbg_run    (i_dbg_run),
    .i_dbg_step   (i_dbg_step),
    .i_dbg_stop   (i_dbg_stop),
    .i_halt_instr (i_halt_instr),
    .bus          (bus),
    .o_state      (o_state),
    .o_halted     (o_halted),
    .o_step_done  (o_step_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one clock, leave inputs changeable 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    #1;
  endtask

  initial begin
    i_rst = 1'b1;
    {i_dbg_run, i_dbg_step, i_dbg_stop, i_halt_instr} = '0;
    bus.i_hazard_stall = 0; bus.i_br_taken = 0; bus.i_jmp_valid = 0;
    bus.i_br_target = '0;   bus.i_jmp_target = '0;
`ifdef PC_SEQ_BKPT_EN
    i_pc = '0; i_bkpt_addr = '0; i_bkpt_valid = 0;
`endif
    tick(); tick();
    i_rst = 1'b0;
    #1;
    chk("rst_state",    o_state, 0);
    chk("rst_halted",   o_halted, 0);
    chk("rst_stepdone", o_step_done, 0);
    chk("rst_pchalt",   bus.o_pc_halt, 1);
    chk("rst_jump",     bus.o_pc_jump, 0);

    // enter RUN
    i_dbg_run = 1; tick(); i_dbg_run = 0; #1;
    chk("run_state",  o_state, 1);
    chk("run_pchalt", bus.o_pc_halt, 0);
    chk("run_jump",   bus.o_pc_jump, 0);
    chk("run_addr",   bus.o_pc_addr2jump, 0);

    // async reset in RUN
    #2 i_rst = 1; #1;
    chk("rst_async_state", o_state, 0);
    tick(); i_rst = 0; #1;

    i_dbg_run = 1; tick(); i_dbg_run = 0; #1;
    chk("run2_state", o_state, 1);

    // branch beats stall
    bus.i_br_taken = 1; bus.i_br_target = 32'h40; bus.i_hazard_stall = 1; #1;
    chk("br_jump",    bus.o_pc_jump, 1);
    chk("br_addr",    bus.o_pc_addr2jump, 32'h40);
    chk("br_flushif", bus.o_flush_if, 1);
    chk("br_flushid", bus.o_flush_id, 1);
    chk("br_stall",   bus.o_pc_stall, 0);
    tick();
    bus.i_br_taken = 0; bus.i_hazard_stall = 0;

    // jump held for 2 stalled cycles
    bus.i_jmp_valid = 1; bus.i_jmp_target = 32'h80; bus.i_hazard_stall = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("jst_stall", bus.o_pc_stall, 1);
      chk("jst_jump",  bus.o_pc_jump, 0);
      chk("jst_addr",  bus.o_pc_addr2jump, 0);
      tick();
    end
    bus.i_hazard_stall = 0; #1;
    chk("jmp_jump",    bus.o_pc_jump, 1);
    chk("jmp_addr",    bus.o_pc_addr2jump, 32'h80);
    chk("jmp_flushif", bus.o_flush_if, 1);
    chk("jmp_flushid", bus.o_flush_id, 0);
    chk("jmp_stall",   bus.o_pc_stall, 0);
    tick();
    bus.i_jmp_valid = 0;

    // HALT with taken branch is wrong-path
    bus.i_br_taken = 1; i_halt_instr = 1; tick();
    bus.i_br_taken = 0; i_halt_instr = 0; #1;
    chk("halt_wrongpath", o_state, 1);

    // HALT with stall is not taken yet
    i_halt_instr = 1; bus.i_hazard_stall = 1; tick();
    bus.i_hazard_stall = 0; #1;
    chk("halt_stalled", o_state, 1);

    // HALT -> DRAIN for 4 cycles -> DONE
    tick(); i_halt_instr = 0; #1;
    chk("drain_state",  o_state, 3);
    chk("drain_pchalt", bus.o_pc_halt, 1);
    bus.i_br_taken = 1; bus.i_br_target = 32'h44; i_dbg_stop = 1; #1;
    chk("drain_nojump", bus.o_pc_jump, 0);
    chk("drain_noflsh", bus.o_flush_id, 0);
    tick(); bus.i_br_taken = 0; i_dbg_stop = 0;
    tick(); tick(); #1;
    chk("drain3_state",  o_state, 3);
    chk("drain3_halted", o_halted, 0);
    tick(); #1;
    chk("done_state",  o_state, 4);
    chk("done_halted", o_halted, 1);
    i_dbg_run = 1; tick(); i_dbg_run = 0; #1;
    chk("done_ignrun", o_state, 4);
    do_reset();
    chk("done_rst_state",  o_state, 0);
    chk("done_rst_halted", o_halted, 0);

    // single step, no stall
    i_dbg_step = 1; tick(); i_dbg_step = 0; #1;
    chk("step_state",  o_state, 2);
    chk("step_pchalt", bus.o_pc_halt, 0);
    tick(); #1;
    chk("step_idle", o_state, 0);
    chk("step_done", o_step_done, 1);
    tick(); #1;
    chk("step_done_clr", o_step_done, 0);

    // stalled step: 4 cycles in STEP, exactly one pulse
    i_dbg_step = 1; tick(); i_dbg_step = 0;
    bus.i_hazard_stall = 1;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("sstep_state", o_state, 2);
      chk("sstep_stall", bus.o_pc_stall, 1);
      tick();
      if (o_step_done) pulses++;
    end
    bus.i_hazard_stall = 0; #1;
    chk("sstep_last", o_state, 2);
    for (int c = 0; c < 3; c++) begin
      tick();
      if (o_step_done) pulses++;
    end
    chk("sstep_pulses", pulses, 1);
    chk("sstep_idle", o_state, 0);

    // HALT during step -> DRAIN, no step_done
    i_dbg_step = 1; tick(); i_dbg_step = 0;
    i_halt_instr = 1; tick(); i_halt_instr = 0; #1;
    chk("shalt_state", o_state, 3);
    chk("shalt_nodone", o_step_done, 0);
    do_reset();
    chk("shalt_rst", o_state, 0);

`ifdef PC_SEQ_BKPT_EN
    i_bkpt_addr = 32'h10; i_bkpt_valid = 1; i_pc = 32'h0c;
    i_dbg_run = 1; tick(); i_dbg_run = 0; #1;
    chk("bk_run", o_state, 1);
    i_pc = 32'h10; #1;
    chk("bk_pchalt", bus.o_pc_halt, 1);
    tick(); #1;
    chk("bk_idle", o_state, 0);
    chk("bk_hit", o_bkpt_hit, 1);
    tick(); #1;
    chk("bk_hit_clr", o_bkpt_hit, 0);
    i_dbg_step = 1; tick(); i_dbg_step = 0; #1;
    chk("bk_step", o_state, 2);
    chk("bk_step_pchalt", bus.o_pc_halt, 0);
    tick(); #1;
    chk("bk_step_done", o_step_done, 1);
    chk("bk_step_nohit", o_bkpt_hit, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Control block that drives the program counter's jump, halt and stall inputs.
- Arbitrates redirect requests: branch resolved in EX, jump decoded in ID.
- Merges hazard-unit stalls with redirects.
- Implements debug-unit execution modes: run, single step, stop, and HALT-instruction drain.
- Sits between the hazard unit, the ID/EX stages, the debug unit and the program counter.

Parameters:
NB_ADDR, 32, width of PC and target addresses
DRAIN_CYCLES, 4, cycles to let pipeline drain after HALT before reporting halted (min 1)

Ports:
clk  in  1  clock
i_rst  in  1  asynchronous reset, active-high
i_dbg_run  in  1  pulse: enter RUN from IDLE
i_dbg_step  in  1  pulse: advance one instruction from IDLE
i_dbg_stop  in  1  pulse: RUN -> IDLE
i_halt_instr  in  1  HALT opcode present in ID
i_hazard_stall  in  1  load-use stall request from hazard unit
i_br_taken  in  1  branch taken, resolved in EX
i_br_target  in  NB_ADDR  branch target
i_jmp_valid  in  1  J/JAL/JR decoded in ID
i_jmp_target  in  NB_ADDR  jump target
o_pc_jump  out  1  to PC jump input
o_pc_addr2jump  out  NB_ADDR  to PC jump-address input
o_pc_halt  out  1  to PC halt input
o_pc_stall  out  1  to PC stall input
o_flush_if  out  1  flush IF/ID register
o_flush_id  out  1  flush ID/EX register
o_state  out  3  current FSM state encoding
o_halted  out  1  registered; high in DONE
o_step_done  out  1  registered; 1-cycle pulse when a step completes

Behaviour:
- States: IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4. Reset -> IDLE, drain counter 0, o_halted=0, o_step_done=0.
- All other outputs are combinational from state and inputs, so a redirect reaches the PC in the same cycle.
- o_pc_halt=1 in IDLE, DRAIN and DONE; 0 in RUN and STEP.
- "Active" means the state is RUN or STEP.
- Redirect priority while active:
  - i_br_taken: o_pc_jump=1, addr=i_br_target, o_flush_if=1, o_flush_id=1, o_pc_stall=0. The branch overrides the stall because it is older than the hazard.
  - Else i_jmp_valid and not i_hazard_stall: o_pc_jump=1, addr=i_jmp_target, o_flush_if=1.
  - Else o_pc_stall=i_hazard_stall and o_pc_jump=0.
- Jump with stall: jump held; ID keeps presenting it and it is taken once the stall clears.
- When no jump is asserted, o_pc_addr2jump=0.
- IDLE: i_dbg_run -> RUN; else i_dbg_step -> STEP. run and step together: run wins.
- RUN:
  - i_br_taken has top priority: stay in RUN, and any i_halt_instr in the same cycle is ignored as wrong-path.
  - Else i_halt_instr and not i_hazard_stall -> DRAIN with counter=DRAIN_CYCLES-1, and PC halted from the next cycle.
  - Else i_dbg_stop -> IDLE.
- STEP:
  - PC advances or redirects once.
  - If o_pc_stall=1 in that cycle, remain in STEP.
  - Otherwise -> IDLE and pulse o_step_done the next cycle.
  - i_halt_instr in STEP (no branch, no stall) -> DRAIN instead, with no o_step_done pulse.
- DRAIN: counter decrements each cycle; at 0 -> DONE. No flush or jump outputs; stop and run are ignored.
- DONE: o_halted=1. Only reset exits; debug pulses are ignored.
- Reset mid-DRAIN or mid-STEP: immediate return to IDLE and all registers cleared.

Optional Feature:
Macro PC_SEQ_BKPT_EN adds ports i_pc[NB_ADDR], i_bkpt_addr[NB_ADDR], i_bkpt_valid, o_bkpt_hit.
- Defined: in RUN, if i_bkpt_valid and i_pc==i_bkpt_addr and no branch, go to IDLE and pulse o_bkpt_hit for 1 cycle (registered).
  - The PC is halted in the same cycle, so the breakpoint instruction is not fetched past.
  - A subsequent i_dbg_step executes past the breakpoint; the breakpoint is not retriggered in STEP.
- Undefined: the ports are absent and there is no breakpoint logic.

Decomposition:
- Package pc_seq_pkg: state localparams (IDLE..DONE), NB_ADDR default, redirect-source enum (NONE, BRANCH, JUMP).
- One sub-module, pc_redirect_arbiter: combinational priority logic producing jump, addr, flush and stall. The FSM and drain counter stay in pc_sequencer.

Test Plan:
- Reset, then i_dbg_run -> o_state=1, o_pc_halt=0, o_pc_jump=0; reset raised in RUN -> o_state=0 immediately.
- RUN, i_br_taken=1 with target 0x40 and i_hazard_stall=1 in the same cycle -> o_pc_jump=1, addr=0x40, o_flush_if=o_flush_id=1, o_pc_stall=0.
- RUN, i_jmp_valid with target 0x80 while stalled 2 cycles -> o_pc_stall=1, o_pc_jump=0 for 2 cycles; then o_pc_jump=1, addr=0x80, o_flush_if=1.
- RUN, i_halt_instr=1 (no stall) -> DRAIN; o_pc_halt=1; exactly 4 cycles later o_state=4 and o_halted=1; i_dbg_run then ignored.
- IDLE, i_dbg_step with no stall -> one cycle with o_pc_halt=0, back to IDLE, o_step_done pulses once; repeat with stall=1 for 3 cycles -> stays in STEP 4 cycles, single pulse.
- (PC_SEQ_BKPT_EN) breakpoint address 0x10, i_pc=0x10 in RUN -> IDLE, o_bkpt_hit pulses once; then step -> o_step_done, no bkpt_hit.
